// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Serial receiver paired with uart_tx. It synchronises the asynchronous line,
//   detects the start bit, samples each data bit at mid-bit (LSB first), checks
//   the stop bit and presents every received word on a valid/ready handshake.
//   Frame: 1 start bit, DLEN data bits, no parity, 1 stop bit, idle high.
//
// Ports
//   clk       in   system clock
//   rstn      in   synchronous active-low reset
//   i_rxs     in   asynchronous serial line, idle high
//   o_rvalid  out  received word available
//   i_rready  in   consumer accepts word
//   o_rdata   out  received word, LSB = first bit on the line
//   o_ferr    out  framing error (stop bit sampled low), qualifies o_rdata
//   o_ovr     out  one-cycle pulse: a completed frame was dropped (overrun)
//
// Handshake: a word transfers on every clk edge where o_rvalid && i_rready.
// While o_rvalid && !i_rready, o_rvalid/o_rdata/o_ferr are held stable.
// o_rvalid is never withdrawn without a transfer, and i_rready may be driven
// independently of o_rvalid. The line itself is never back-pressured.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD = 921600,
  parameter int CLKF = 100000000,
  parameter int DLEN = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_rxs,
  output logic            o_rvalid,
  input  logic            i_rready,
  output logic [DLEN-1:0] o_rdata,
  output logic            o_ferr,
  output logic            o_ovr
);

  localparam int BaudLimit = CLKF / BAUD - 1;
  localparam int HalfLimit = BaudLimit / 2;
  localparam int CW        = $clog2(BaudLimit + 1);
  localparam int BW        = $clog2(DLEN + 1);

  localparam logic [CW-1:0] BaudLim = CW'(BaudLimit);
  localparam logic [CW-1:0] HalfLim = CW'(HalfLimit);
  localparam logic [BW-1:0] LastBit = BW'(DLEN - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    STOP  = 5'b01000,
    BRK   = 5'b10000
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bits;
  logic [DLEN-1:0] r_shift;
  logic            r_rvalid;
  logic [DLEN-1:0] r_rdata;
  logic            r_ferr;
  logic            r_ovr;

  logic            w_rxs;
  logic            w_tick;
  logic            w_can_load;

  // Two-flop synchroniser; both flops reset to the idle line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxs;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // START waits half a bit so that every later tick lands at mid-bit.
  always_comb begin
    w_tick = 1'b0;
    if (r_state == START) w_tick = (r_cnt == HalfLim);
    else                  w_tick = (r_cnt == BaudLim);
  end

  // A new word may be loaded if the holding slot is empty or is being
  // emptied by a handshake in this very cycle.
  assign w_can_load = !r_rvalid || i_rready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_shift  <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_rvalid && i_rready) r_rvalid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rxs) r_state <= START;
        end

        START: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_bits <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            r_state <= w_rxs ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[DLEN-1:1]};
            r_bits  <= r_bits + 1'b1;
            if (r_bits == LastBit) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (w_can_load) begin
              r_rdata  <= r_shift;
              r_ferr   <= ~w_rxs;
              r_rvalid <= 1'b1;
            end else begin
              r_ovr <= 1'b1;
            end
            // A low stop bit may be a break; wait for the line to recover
            // instead of decoding the low level as further frames.
            r_state <= w_rxs ? IDLE : BRK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        BRK: begin
          r_cnt <= '0;
          if (w_rxs) r_state <= IDLE;
        end

        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_bits   <= '0;
          r_shift  <= '0;
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
          r_ferr   <= 1'b0;
          r_ovr    <= 1'b0;
        end
      endcase
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_ferr   = r_ferr;
  assign o_ovr    = r_ovr;

endmodule
